cache_flush_unit: RTL

Per-cache flush sequencer and request gate, placed between the core request ports and the bank selector. It generalises single-mode flush handling in four ways: it supports two flush modes, latches the set of requesting ports when a flush starts, tracks in-flight requests with a sized counter, and reports flush duration. When a flush request appears, it blocks all core requests, drains requests in the bank-select pipeline, pulses a flush to every bank, and waits for all banks to finish. It then releases only the flush requests captured at flush start.

---
 rtl/cache_flush_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/cache_flush_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_flush_unit : gates core requests, drains the bank-select pipeline,
// pulses bank flushes and releases the flush requests captured at start. r1.0
// ---------------------------------------------------------------------------
module cache_flush_unit #(
  parameter int NUM_REQS         = 4,
  parameter int NUM_BANKS        = 1,
  parameter int BANK_SEL_LATENCY = 1,
  parameter int CYCLE_W          = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQS-1:0]  core_req_valid_in,
  input  logic [NUM_REQS-1:0]  core_req_flush_in,
  input  logic [NUM_REQS-1:0]  core_req_mode_in,
  output logic [NUM_REQS-1:0]  core_req_ready_in,
  output logic [NUM_REQS-1:0]  core_req_valid_out,
  input  logic [NUM_REQS-1:0]  core_req_ready_out,
  input  logic [NUM_BANKS-1:0] bank_req_fire,
  output logic [NUM_BANKS-1:0] flush_begin,
  output logic                 flush_mode,
  input  logic [NUM_BANKS-1:0] flush_end,
  output logic                 flush_busy,
  output logic [CYCLE_W-1:0]   flush_cycles
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WAIT1 = 3'd1;
  localparam logic [2:0] FLUSH = 3'd2;
  localparam logic [2:0] WAIT2 = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int MAX_INFL = BANK_SEL_LATENCY * NUM_BANKS;
  localparam int CNT_W    = (MAX_INFL > 0) ? $clog2(MAX_INFL + 1) : 1;
  localparam int SUM_W    = CNT_W + $clog2(NUM_REQS + NUM_BANKS + 1) + 1;
  localparam logic [CYCLE_W-1:0] CYC_MAX = '1;

  logic [2:0]           state;
  logic [NUM_REQS-1:0]  cap;
  logic [NUM_REQS-1:0]  rel;
  logic [NUM_BANKS-1:0] done;
  logic                 mode_r;
  logic [CYCLE_W-1:0]   cyc;
  logic [CYCLE_W-1:0]   cycles_r;

  logic [NUM_REQS-1:0]  fmask;
  logic [NUM_REQS-1:0]  en;
  logic [NUM_REQS-1:0]  accepted;
  logic [NUM_REQS-1:0]  rel_next;
  logic [NUM_BANKS-1:0] done_next;
  logic [CYCLE_W-1:0]   cyc_inc;
  logic                 open_gate;
  logic                 pipe_empty;

  assign fmask     = core_req_valid_in & core_req_flush_in;
  // A pending flush closes the gate in the same cycle it appears.
  assign open_gate = (state == IDLE) && (fmask == '0);
  assign en        = {NUM_REQS{open_gate}} | rel;

  assign core_req_valid_out = core_req_valid_in & en;
  assign core_req_ready_in  = core_req_ready_out & en;
  assign accepted           = core_req_valid_out & core_req_ready_out;

  assign done_next = done | flush_end;
  assign rel_next  = rel & ~core_req_ready_out;
  assign cyc_inc   = (cyc == CYC_MAX) ? cyc : cyc + CYCLE_W'(1);

  assign flush_begin  = {NUM_BANKS{state == FLUSH}};
  assign flush_busy   = (state != IDLE);
  assign flush_mode   = mode_r;
  assign flush_cycles = cycles_r;

  generate
    if (BANK_SEL_LATENCY > 0) begin : g_inflight
      logic [CNT_W-1:0] count;
      logic [SUM_W-1:0] add_n;
      logic [SUM_W-1:0] sub_n;
      logic [SUM_W-1:0] base_n;

      always_comb begin
        add_n = '0;
        sub_n = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
          add_n = add_n + SUM_W'(accepted[i]);
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
          sub_n = sub_n + SUM_W'(bank_req_fire[b]);
        end
        base_n = SUM_W'(count) + add_n;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          count <= '0;
        end else begin
          assert (base_n >= sub_n);
          assert ((base_n - sub_n) <= SUM_W'(MAX_INFL));
          count <= CNT_W'(base_n - sub_n);
        end
      end

      assign pipe_empty = (count == '0);
    end else begin : g_no_inflight
      assign pipe_empty = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cap      <= '0;
      rel      <= '0;
      done     <= '0;
      mode_r   <= 1'b0;
      cyc      <= '0;
      cycles_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fmask != '0) begin
            cap    <= fmask;
            // Invalidate-only only when every captured request asks for it.
            mode_r <= &(core_req_mode_in | ~fmask);
            state  <= (BANK_SEL_LATENCY == 0) ? FLUSH : WAIT1;
          end
        end
        WAIT1: begin
          if (pipe_empty) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          cyc   <= '0;
          state <= WAIT2;
        end
        WAIT2: begin
          cyc <= cyc_inc;
          if (&done_next) begin
            rel      <= cap;
            done     <= '0;
            cycles_r <= cyc_inc;
            state    <= DONE;
          end else begin
            done <= done_next;
          end
        end
        DONE: begin
          rel <= rel_next;
          if (rel_next == '0) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
